// File: rtl/bin_bcd_formatter_pkg.sv
// bin_bcd_formatter_pkg
// Purpose : shared constants, FSM state encoding and the leading-zero
//           blanking helper for the binary-to-BCD display formatter.
// Ports   : none (package).
package bin_bcd_formatter_pkg;

  localparam int BIN_W  = 27;
  localparam int DIGITS = 8;
  localparam int BCD_W  = 4 * DIGITS;
  localparam int CNT_W  = 5;

  localparam logic [BIN_W-1:0] MAX_VAL  = 27'd99_999_999;
  localparam logic [3:0]       CODE_E   = 4'hE;
  localparam logic [CNT_W-1:0] CNT_LOAD = 5'd27;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SHIFT  = 2'b01,
    ST_FORMAT = 2'b10
  } state_e;

  // Digit enables with leading-zero blanking. Walking from SEG1 (most
  // significant) towards SEG8, a digit lights once any digit at or above it
  // is nonzero or carries a decimal point; SEG8 always lights.
  // Enable bit [DIGITS-1] is SEG1, bit [0] is SEG8.
  function automatic logic [DIGITS-1:0] lz_enables(
    input logic [BCD_W-1:0]  bcd,
    input logic [DIGITS-1:0] dots
  );
    logic              seen;
    logic [DIGITS-1:0] en;
    seen = 1'b0;
    en   = {DIGITS{1'b0}};
    for (int k = 0; k < DIGITS; k++) begin
      seen = seen | (bcd[BCD_W-1-4*k -: 4] != 4'h0) | dots[DIGITS-1-k];
      en[DIGITS-1-k] = seen;
    end
    en[0] = 1'b1;
    return en;
  endfunction

endpackage

// File: rtl/bin_bcd_formatter_if.sv
// bin_bcd_formatter_if
// Purpose : request/result bundle between a value producer and the formatter.
// Signals : in_valid/in_ready request handshake, bin value, blank_lz and
//           dot_mask display options; dat_1..dat_8 BCD digits (dat_1 = SEG1),
//           dat_en/dot_en per-digit enables, done pulse, overflow flag.
// Modports: master = value producer, slave = formatter.
interface bin_bcd_formatter_if;
  import bin_bcd_formatter_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [BIN_W-1:0]  bin;
  logic              blank_lz;
  logic [DIGITS-1:0] dot_mask;
  logic [3:0]        dat_1;
  logic [3:0]        dat_2;
  logic [3:0]        dat_3;
  logic [3:0]        dat_4;
  logic [3:0]        dat_5;
  logic [3:0]        dat_6;
  logic [3:0]        dat_7;
  logic [3:0]        dat_8;
  logic [DIGITS-1:0] dat_en;
  logic [DIGITS-1:0] dot_en;
  logic              done;
  logic              overflow;

  modport master (
    output in_valid, bin, blank_lz, dot_mask,
    input  in_ready, dat_1, dat_2, dat_3, dat_4, dat_5, dat_6, dat_7, dat_8,
    input  dat_en, dot_en, done, overflow
  );

  modport slave (
    input  in_valid, bin, blank_lz, dot_mask,
    output in_ready, dat_1, dat_2, dat_3, dat_4, dat_5, dat_6, dat_7, dat_8,
    output dat_en, dot_en, done, overflow
  );

endinterface

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj
// Purpose : double-dabble nibble adjust; adds 3 to a BCD nibble >= 5 so the
//           following left shift carries correctly into the next digit.
// Ports   : d_i - nibble before adjust; d_o - adjusted nibble.
module bcd_digit_adj (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  // Combinational add-3 adjust.
  always_comb begin
    if (d_i >= 4'd5) begin
      d_o = d_i + 4'd3;
    end else begin
      d_o = d_i;
    end
  end

endmodule

// File: rtl/bin_bcd_formatter.sv
// bin_bcd_formatter
// Purpose : converts a 27-bit unsigned value into eight BCD digits with
//           double-dabble (one bit per clock), then applies leading-zero
//           blanking, decimal points and overflow coding, and presents all
//           results to the segment scan block in a single atomic update.
// Ports   : clk   - system clock, rising edge
//           rst_n - asynchronous active-low reset
//           bus   - bin_bcd_formatter_if slave (request in, digits out)
module bin_bcd_formatter
  import bin_bcd_formatter_pkg::*;
(
  input logic                clk,
  input logic                rst_n,
  bin_bcd_formatter_if.slave bus
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIN_W-1:0]  bin_sh_q, bin_sh_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic              blank_q, blank_d;
  logic [DIGITS-1:0] dot_cap_q, dot_cap_d;
  logic              big_q, big_d;
  logic [BCD_W-1:0]  dat_q, dat_d;
  logic [DIGITS-1:0] dat_en_q, dat_en_d;
  logic [DIGITS-1:0] dot_en_q, dot_en_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;
  logic              ready_q, ready_d;
  logic [BCD_W-1:0]  bcd_adj_s;

  // One add-3 adjuster per BCD digit of the accumulator.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d_i (bcd_q[4*g +: 4]),
      .d_o (bcd_adj_s[4*g +: 4])
    );
  end

  // Next-state, datapath and output update logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bin_sh_d  = bin_sh_q;
    bcd_d     = bcd_q;
    blank_d   = blank_q;
    dot_cap_d = dot_cap_q;
    big_d     = big_q;
    dat_d     = dat_q;
    dat_en_d  = dat_en_q;
    dot_en_d  = dot_en_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          bin_sh_d  = bus.bin;
          blank_d   = bus.blank_lz;
          dot_cap_d = bus.dot_mask;
          // Overflow is decided from the raw value: the eight-digit
          // accumulator cannot represent anything above MAX_VAL.
          big_d     = (bus.bin > MAX_VAL);
          bcd_d     = {BCD_W{1'b0}};
          cnt_d     = CNT_LOAD;
          state_d   = ST_SHIFT;
        end else begin
          state_d   = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        bcd_d    = {bcd_adj_s[BCD_W-2:0], bin_sh_q[BIN_W-1]};
        bin_sh_d = {bin_sh_q[BIN_W-2:0], 1'b0};
        cnt_d    = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d = ST_FORMAT;
        end else begin
          state_d = ST_SHIFT;
        end
      end

      ST_FORMAT: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
        if (big_q) begin
          dat_d    = {DIGITS{CODE_E}};
          dat_en_d = {DIGITS{1'b1}};
          dot_en_d = {DIGITS{1'b0}};
          ovf_d    = 1'b1;
        end else begin
          dat_d    = bcd_q;
          if (blank_q) begin
            dat_en_d = lz_enables(bcd_q, dot_cap_q);
          end else begin
            dat_en_d = {DIGITS{1'b1}};
          end
          dot_en_d = dot_cap_q;
          ovf_d    = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      bin_sh_q  <= {BIN_W{1'b0}};
      bcd_q     <= {BCD_W{1'b0}};
      blank_q   <= 1'b0;
      dot_cap_q <= {DIGITS{1'b0}};
      big_q     <= 1'b0;
      dat_q     <= {BCD_W{1'b0}};
      dat_en_q  <= {DIGITS{1'b0}};
      dot_en_q  <= {DIGITS{1'b0}};
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bin_sh_q  <= bin_sh_d;
      bcd_q     <= bcd_d;
      blank_q   <= blank_d;
      dot_cap_q <= dot_cap_d;
      big_q     <= big_d;
      dat_q     <= dat_d;
      dat_en_q  <= dat_en_d;
      dot_en_q  <= dot_en_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
    end
  end

  assign bus.in_ready = ready_q;
  assign bus.dat_1    = dat_q[31:28];
  assign bus.dat_2    = dat_q[27:24];
  assign bus.dat_3    = dat_q[23:20];
  assign bus.dat_4    = dat_q[19:16];
  assign bus.dat_5    = dat_q[15:12];
  assign bus.dat_6    = dat_q[11:8];
  assign bus.dat_7    = dat_q[7:4];
  assign bus.dat_8    = dat_q[3:0];
  assign bus.dat_en   = dat_en_q;
  assign bus.dot_en   = dot_en_q;
  assign bus.done     = done_q;
  assign bus.overflow = ovf_q;

endmodule
